// File: rtl/refill_arbiter.sv
// rtl/refill_arbiter.sv - round-robin arbiter serialising cache line refills/writebacks onto one memory port.
// Define REFILL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module refill_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]          req_we_i,
    input  logic [NUM_REQ*LINE_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          resp_valid_o,
    output logic [LINE_W-1:0]           resp_rdata_o,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic [ADDR_W-1:0]           mem_req_addr_o,
    output logic                        mem_req_we_o,
    output logic [LINE_W-1:0]           mem_req_wdata_o,
    input  logic                        mem_resp_valid_i,
    input  logic [LINE_W-1:0]           mem_resp_rdata_i,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [LINE_W-1:0]  r_wdata;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_found;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic               w_accept;
    logic               w_resp;

    // Scan downward so the candidate nearest the pointer is the last (winning) assignment.
    always_comb begin
        int               v_sum;
        logic [IDX_W-1:0] v_idx;
        v_sum       = 0;
        v_idx       = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            v_sum = int'(r_rr_ptr) + i;
            if (v_sum >= NUM_REQ) begin
                v_sum = v_sum - NUM_REQ;
            end
            v_idx = IDX_W'(v_sum);
            if (req_valid_i[v_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = v_idx;
            end
        end
    end

`ifdef REFILL_ARB_FIXED_PRIO_EN
    assign w_rr_nxt = '0;
`else
    assign w_rr_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
`endif

    assign w_accept = (r_state == S_IDLE) && w_win_found;
    assign w_resp   = (r_state == S_WAIT) && mem_resp_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win_found)      w_state_nxt = S_ISSUE;
            S_ISSUE: if (mem_req_ready_i)  w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_resp_valid_i) w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_win_idx;
                r_addr  <= req_addr_i[w_win_idx*ADDR_W +: ADDR_W];
                r_we    <= req_we_i[w_win_idx];
                r_wdata <= req_wdata_i[w_win_idx*LINE_W +: LINE_W];
            end
            if (w_resp) begin
                r_rr_ptr <= w_rr_nxt;
            end
        end
    end

    // The grant is combinational from req_valid_i, so it is masked while reset is held.
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        if (w_accept && !rst_i) begin
            req_ready_o[w_win_idx] = 1'b1;
        end
        if (w_resp) begin
            resp_valid_o[r_owner] = 1'b1;
        end
    end

    assign resp_rdata_o    = w_resp ? mem_resp_rdata_i : '0;
    assign mem_req_valid_o = (r_state == S_ISSUE);
    assign mem_req_addr_o  = r_addr;
    assign mem_req_we_o    = r_we;
    assign mem_req_wdata_o = r_wdata;
    assign busy_o          = (r_state != S_IDLE);

endmodule

// File: doc/refill_arbiter.md
REFILL_ARBITER -- requirements
Module: refill_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the requester count (0 = ICache refill, 1 = DCache MSHR refill, 2 = DCache writeback); legal range 2..8.
REQ-002 Parameter ADDR_W, default 32, SHALL set the physical line address width (PLEN).
REQ-003 Parameter LINE_W, default 512, SHALL set the line payload width (ICACHE_LINE_WIDTH / DCACHE_LINE_WIDTH).
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-008 req_ready_o  out  NUM_REQ  per-requester acceptance, at most one bit set.
REQ-009 req_addr_i  in  NUM_REQ*ADDR_W  per-requester line address, slice i = requester i.
REQ-010 req_we_i  in  NUM_REQ  per-requester write flag (1 = writeback).
REQ-011 req_wdata_i  in  NUM_REQ*LINE_W  per-requester write line.
REQ-012 resp_valid_o  out  NUM_REQ  one-cycle response strobe to the transaction owner.
REQ-013 resp_rdata_o  out  LINE_W  shared response line, valid only with a resp_valid_o bit.
REQ-014 mem_req_valid_o / mem_req_ready_i  out/in  1/1  downstream request handshake.
REQ-015 mem_req_addr_o / mem_req_we_o / mem_req_wdata_o  out  ADDR_W/1/LINE_W  downstream request fields.
REQ-016 mem_resp_valid_i / mem_resp_rdata_i  in  1/LINE_W  downstream response (read data, or write ack with don't-care data).
REQ-017 busy_o  out  1  high whenever a transaction is accepted and not yet responded to.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT; exactly one transaction SHALL be outstanding at a time.
REQ-019 IDLE: if any req_valid_i bit is set, the winner SHALL be selected this cycle, req_ready_o[winner] SHALL be 1 combinationally, addr/we/wdata and owner index SHALL be latched, next state ISSUE.
REQ-020 req_ready_o SHALL be all-zero outside IDLE and in IDLE with no valid request.
REQ-021 Round-robin: the winner SHALL be the first set req_valid_i bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-022 ISSUE: mem_req_valid_o SHALL be 1 with latched fields held stable until mem_req_ready_i; on handshake next state WAIT; latency acceptance -> mem_req_valid_o SHALL be exactly 1 cycle.
REQ-023 WAIT: on mem_resp_valid_i, resp_valid_o[owner] SHALL be 1 for that single cycle, resp_rdata_o SHALL equal mem_resp_rdata_i combinationally, rr_ptr SHALL become (owner+1) mod NUM_REQ, next state IDLE.
REQ-024 No request SHALL be accepted in the response cycle; the next arbitration SHALL occur in the following IDLE cycle.
REQ-025 mem_resp_valid_i in IDLE or ISSUE SHALL be ignored with no output effect.
REQ-026 Requester changes of req_* after acceptance SHALL NOT affect the in-flight transaction.
REQ-027 mem_req_valid_o SHALL NOT be deasserted in ISSUE before mem_req_ready_i.
REQ-028 busy_o SHALL equal (state != IDLE).

Reset
REQ-029 On rst_i: state IDLE, rr_ptr 0, latched fields 0, all outputs 0 asynchronously.
REQ-030 Reset mid-transaction SHALL abandon it; a late mem_resp_valid_i after reset SHALL be ignored per REQ-025.

Configuration
REQ-031 Macro REFILL_ARB_FIXED_PRIO_EN defined: winner SHALL be the lowest-index valid requester and rr_ptr SHALL stay 0; undefined: round-robin per REQ-021.

Verification
REQ-032 Reset, then idle 5 cycles -> all outputs 0, busy_o 0.
REQ-033 Req 1 alone, addr 0x8000_0040, ready held 0 for 3 cycles -> req_ready_o=3'b010 in cycle 0, mem_req_valid_o high cycles 1-4 with stable addr, resp 0xAA..AA -> resp_valid_o=3'b010 one cycle.
REQ-034 All three valid continuously, immediate ready/resp (round-robin build) -> grants in order 0,1,2,0 with one IDLE bubble after each response.
REQ-035 Same stimulus with REFILL_ARB_FIXED_PRIO_EN -> requester 0 granted every transaction.
REQ-036 Req 2 writeback (we=1) in ISSUE, rst_i asserted, then mem_resp_valid_i after reset -> outputs 0, resp_valid_o stays 0, state IDLE.
REQ-037 Spurious mem_resp_valid_i in IDLE -> no resp_valid_o, no rr_ptr change.
